// File: rtl/d5m_stream_packer_pkg.sv
// rtl/d5m_stream_packer_pkg.sv - shared beat type, FSM states and colour-bar helper for d5m_stream_packer
package d5m_stream_packer_pkg;

  localparam int D5M_DATA_W = 24;
  localparam int D5M_BAR_SHIFT = 5;  // bar index is x[7:5]: 32-pixel-wide bars

  typedef struct packed {
    logic                  tuser;
    logic                  tlast;
    logic [D5M_DATA_W-1:0] tdata;
  } d5m_beat_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DROP
  } d5m_pack_state_e;

  // Bar i -> {R,G,B} with each channel fully on or off from one bit of i
  function automatic logic [D5M_DATA_W-1:0] bar_colour(input logic [2:0] i);
    return {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
  endfunction

endpackage

// File: rtl/d5m_stream_packer_if.sv
// rtl/d5m_stream_packer_if.sv - AXI4-Stream video bus carrying packed D5M pixels
interface d5m_stream_packer_if;
  import d5m_stream_packer_pkg::*;

  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;
  logic [D5M_DATA_W-1:0] tdata;

  modport master (output tvalid, output tlast, output tuser, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tuser, input tdata, output tready);

endinterface

// File: rtl/d5m_stream_packer_fifo.sv
// rtl/d5m_stream_packer_fifo.sv - sync beat FIFO with a registered stream output stage
module d5m_stream_fifo
  import d5m_stream_packer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                pixclk,
  input  logic                reset,
  input  logic                push,
  input  d5m_beat_t           push_beat,
  output logic                push_ready,
  d5m_stream_packer_if.master m_axis
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  d5m_beat_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           out_v;
  d5m_beat_t      out_b;
  logic           pop;
  logic           do_push;

  // Refill the output register whenever it is empty or its beat is being taken;
  // a push into a full FIFO is still accepted when a pop frees a slot the same cycle.
  assign pop        = (count != '0) && (!out_v || m_axis.tready);
  assign push_ready = (count != FULL_CNT) || pop;
  assign do_push    = push && push_ready;

  assign m_axis.tvalid = out_v;
  assign m_axis.tlast  = out_b.tlast;
  assign m_axis.tuser  = out_b.tuser;
  assign m_axis.tdata  = out_b.tdata;

  // Storage array write port, no reset needed on payload
  always_ff @(posedge pixclk) begin
    if (do_push) mem[wr_ptr] <= push_beat;
  end

  // Pointers, occupancy and registered output; output holds while stalled
  always_ff @(posedge pixclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      out_v  <= 1'b0;
      out_b  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        out_b  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      out_v <= pop || (out_v && !m_axis.tready);
      if (do_push && !pop)      count <= count + (AW + 1)'(1);
      else if (!do_push && pop) count <= count - (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/d5m_stream_packer.sv
// rtl/d5m_stream_packer.sv - D5M fval/lval pixel bus to AXI4-Stream video packer (optional D5M_PACK_PATTERN_EN colour bars)
module d5m_stream_packer
  import d5m_stream_packer_pkg::*;
#(
  parameter int DATA_W     = D5M_DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                pixclk,
  input  logic                reset,
  input  logic                enable,
  input  logic                ifval,
  input  logic                ilval,
  input  logic [DATA_W-1:0]   idata,
`ifdef D5M_PACK_PATTERN_EN
  input  logic                pattern_sel,
`endif
  d5m_stream_packer_if.master m_axis,
  output logic                overflow,
  output logic [CNT_W-1:0]    frame_count
);

  d5m_pack_state_e       state, state_nxt;
  logic                  ifval_q;
  logic                  lv, lv_q;
  logic                  hold_v;
  logic [DATA_W-1:0]     hold_d;
  logic [DATA_W-1:0]     pix;
  logic                  sof;
  logic                  push, push_tlast, push_ready;
  logic                  capture, hold_clr, frame_done, drop, start;
  d5m_beat_t             push_beat;

  // Line valid only counts inside a frame
  assign lv = ifval && ilval;

`ifdef D5M_PACK_PATTERN_EN
  logic [7:0] x_pos;

  // Horizontal pixel position within the current line, restarts when lval drops
  always_ff @(posedge pixclk) begin
    if (reset) x_pos <= '0;
    else       x_pos <= lv ? x_pos + 8'd1 : 8'd0;
  end

  assign pix = pattern_sel ? bar_colour(x_pos[7:D5M_BAR_SHIFT]) : idata;
`else
  assign pix = idata;
`endif

  assign push_beat = '{tuser: sof, tlast: push_tlast, tdata: hold_d};

  // Next-state and per-cycle actions: hold register shifting, EOL tagging, drop detection
  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    push_tlast = 1'b0;
    capture    = 1'b0;
    hold_clr   = 1'b0;
    frame_done = 1'b0;
    drop       = 1'b0;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        if (ifval && !ifval_q && enable) begin
          state_nxt = ACTIVE;
          start     = 1'b1;
          capture   = lv;
        end
      end
      ACTIVE: begin
        if (!ifval) begin
          push       = hold_v;
          push_tlast = 1'b1;
          hold_clr   = 1'b1;
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else if (lv) begin
          push    = hold_v;
          capture = 1'b1;
        end else if (lv_q && hold_v) begin
          push       = 1'b1;
          push_tlast = 1'b1;
          hold_clr   = 1'b1;
        end
        if (push && !push_ready) begin
          drop       = 1'b1;
          frame_done = 1'b0;
          state_nxt  = ifval ? DROP : IDLE;
        end
      end
      DROP: begin
        if (!ifval) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, edge-detect history, hold register, SOF flag and status counters
  always_ff @(posedge pixclk) begin
    if (reset) begin
      state       <= IDLE;
      ifval_q     <= 1'b1;  // a frame already in flight at reset must not look like a rising edge
      lv_q        <= 1'b0;
      hold_v      <= 1'b0;
      hold_d      <= '0;
      sof         <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      state   <= state_nxt;
      ifval_q <= ifval;
      lv_q    <= lv;
      if (start)                   sof <= 1'b1;
      else if (push && push_ready) sof <= 1'b0;
      if (drop || hold_clr) begin
        hold_v <= 1'b0;
      end else if (capture) begin
        hold_v <= 1'b1;
        hold_d <= pix;
      end
      if (drop)       overflow    <= 1'b1;
      if (frame_done) frame_count <= frame_count + CNT_W'(1);
    end
  end

  d5m_stream_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .pixclk     (pixclk),
    .reset      (reset),
    .push       (push),
    .push_beat  (push_beat),
    .push_ready (push_ready),
    .m_axis     (m_axis)
  );

endmodule
